// File: rtl/mem_word_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_word_loader_if
//  Brief    : Control, byte-stream and memory write-port bundle of the boot
//             loader. "master" is the loader's view (it drives the memory
//             write port); "slave" is the view of whatever surrounds it.
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_word_loader_if #(
    parameter int ADDR_W = 14,
    parameter int CNT_W  = 13
) ();
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  num_words;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  start, base_addr, num_words, byte_in, byte_valid,
        output byte_ready, mem_addr, mem_wdata, mem_we, busy, done, err
    );

    modport slave (
        output start, base_addr, num_words, byte_in, byte_valid,
        input  byte_ready, mem_addr, mem_wdata, mem_we, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/mem_word_loader.sv
`default_nettype none
// ============================================================================
//  Module   : mem_word_loader
//  Brief    : Boot-time loader. Packs a byte stream into 32-bit little-endian
//             words and writes them to consecutive word addresses starting at
//             a programmable base. Flags loads that would run off the end of
//             memory and reports completion with a one-cycle done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_word_loader #(
    parameter int ADDR_W    = 14,
    parameter int MAX_WORDS = 4096
) (
    input  wire              clk,
    input  wire              rst,
    mem_word_loader_if.master bus
);

    localparam int CNT_W = 13;

    // End-of-load bound, one bit wider than the address so base+count never wraps.
    localparam logic [ADDR_W:0] c_max_words = (ADDR_W+1)'(MAX_WORDS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_idx;
    logic [23:0]       r_pack;       // lanes 0..2; lane 3 goes straight to mem_wdata
    logic              r_err;
    logic              r_busy;
    logic              r_done;
    logic              r_byte_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;

    logic [ADDR_W:0]   w_end;
    logic              w_range_bad;
    logic              w_xfer;

    // Range check on the requested load, evaluated against the live start inputs.
    assign w_end       = (ADDR_W+1)'(bus.base_addr) + (ADDR_W+1)'(bus.num_words);
    assign w_range_bad = (w_end > c_max_words);
    assign w_xfer      = bus.byte_valid && r_byte_ready;

    // Loader state machine; every output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_cnt        <= '0;
            r_idx        <= 2'd0;
            r_pack       <= '0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_byte_ready <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            // Single-cycle strobes default low; mem_addr/mem_wdata hold.
            r_mem_we <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_addr <= bus.base_addr;
                        r_cnt  <= bus.num_words;
                        r_err  <= 1'b0;
                        r_idx  <= 2'd0;
                        if (bus.num_words == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else if (w_range_bad) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state      <= S_COLLECT;
                            r_busy       <= 1'b1;
                            r_byte_ready <= 1'b1;
                        end
                    end
                end
                S_COLLECT: begin
                    if (w_xfer) begin
                        r_idx <= r_idx + 2'd1;
                        case (r_idx)
                            2'd0: r_pack[7:0]   <= bus.byte_in;
                            2'd1: r_pack[15:8]  <= bus.byte_in;
                            2'd2: r_pack[23:16] <= bus.byte_in;
                            2'd3: begin
                                // Fourth byte completes the word: issue the write next cycle.
                                r_mem_we     <= 1'b1;
                                r_mem_addr   <= r_addr;
                                r_mem_wdata  <= {bus.byte_in, r_pack};
                                r_byte_ready <= 1'b0;
                                r_state      <= S_WRITE;
                            end
                            default: ;
                        endcase
                    end
                end
                S_WRITE: begin
                    r_addr <= r_addr + ADDR_W'(1);
                    r_cnt  <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state      <= S_COLLECT;
                        r_byte_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.byte_ready = r_byte_ready;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.mem_we     = r_mem_we;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.err        = r_err;

endmodule
`default_nettype wire
